// File: rtl/ssb_sync_pkg.sv
// ssb_sync_pkg: shared FSM states, SSB symbol indices and alignment helper
package ssb_sync_pkg;
    typedef enum logic [2:0] {
        SEARCH = 3'd0,
        ALIGN  = 3'd1,
        SYM    = 3'd2,
        CP     = 3'd3,
        TRACK  = 3'd4
    } state_t;
    localparam logic [1:0] SYM_PSS   = 2'd0;
    localparam logic [1:0] SYM_PBCH1 = 2'd1;
    localparam logic [1:0] SYM_SSS   = 2'd2;
    localparam logic [1:0] SYM_PBCH2 = 2'd3;
    // samples still left in the first cyclic prefix when the peak pulse arrives
    function automatic int wait_cycles(input int cp_len, input int detection_delay);
        return cp_len - detection_delay;
    endfunction
endpackage

// File: rtl/ssb_period_tracker.sv
// ssb_period_tracker: SSB period counter, search window and consecutive-miss bookkeeping
module ssb_period_tracker
    import ssb_sync_pkg::*;
#(
    parameter int SSB_PERIOD = 76800,
    parameter int SEARCH_WIN = 8,
    parameter int MISS_LIMIT = 3
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              valid,
    input  logic                              peak,
    input  state_t                            state,
    output logic                              hit,
    output logic                              lost,
    output logic [$clog2(MISS_LIMIT+1)-1:0]   miss_count
);
    localparam int PERIOD_W = $clog2(SSB_PERIOD + SEARCH_WIN + 1);
    localparam int MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [PERIOD_W-1:0] WIN_LO    = PERIOD_W'(SSB_PERIOD - SEARCH_WIN);
    localparam logic [PERIOD_W-1:0] WIN_HI    = PERIOD_W'(SSB_PERIOD + SEARCH_WIN);
    localparam logic [PERIOD_W-1:0] FLYWHEEL  = PERIOD_W'(SEARCH_WIN);
    localparam logic [MISS_W-1:0]   MISS_LAST = MISS_W'(MISS_LIMIT - 1);
    logic [PERIOD_W-1:0] period_cnt;
    logic tracking, close, restart;
    // a peak on the last window sample is a hit, so close only fires without one
    always_comb begin
        tracking = state == TRACK;
        hit      = tracking && peak && period_cnt >= WIN_LO && period_cnt <= WIN_HI;
        close    = tracking && valid && period_cnt == WIN_HI && !hit;
        lost     = close && miss_count == MISS_LAST;
        restart  = hit || (state == SEARCH && peak);
    end
    // flywheel reload keeps the nominal phase after a missed peak
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            period_cnt <= '0;
            miss_count <= '0;
        end else begin
            if (restart)
                period_cnt <= '0;
            else if (close)
                period_cnt <= FLYWHEEL;
            else if (valid && state != SEARCH && period_cnt != WIN_HI)
                period_cnt <= period_cnt + 1'b1;
            if (hit || lost)
                miss_count <= '0;
            else if (close)
                miss_count <= miss_count + 1'b1;
        end
    end
endmodule

// File: rtl/ssb_sync_ctrl.sv
// ssb_sync_ctrl: gates the FFT over the three post-PSS SSB symbols and tracks the SSB period
module ssb_sync_ctrl
    import ssb_sync_pkg::*;
#(
    parameter int FFT_LEN         = 256,
    parameter int CP_LEN          = 18,
    parameter int DETECTION_DELAY = 15,
    parameter int SSB_PERIOD      = 76800,
    parameter int SEARCH_WIN      = 8,
    parameter int MISS_LIMIT      = 3
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            s_axis_in_tvalid,
    input  logic                            peak_detected_i,
    output logic                            fft_enable_o,
    output logic                            symbol_start_o,
    output logic [1:0]                      symbol_idx_o,
    output logic                            PBCH_start_o,
    output logic                            SSS_start_o,
    output logic                            locked_o,
    output logic [$clog2(MISS_LIMIT+1)-1:0] miss_count_o,
    output logic [2:0]                      state_debug_o
);
    localparam int WAIT_LEN = wait_cycles(CP_LEN, DETECTION_DELAY);
    localparam int CNT_W    = $clog2(FFT_LEN + CP_LEN + WAIT_LEN + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LEN - 1);
    localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(FFT_LEN - 1);
    localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN - 1);
    localparam state_t ENTRY = (WAIT_LEN == 0) ? SYM : ALIGN;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0] idx_nx;
    logic locked_nx, sym_first, hit, lost;
    ssb_period_tracker #(
        .SSB_PERIOD (SSB_PERIOD),
        .SEARCH_WIN (SEARCH_WIN),
        .MISS_LIMIT (MISS_LIMIT)
    ) u_tracker (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .valid      (s_axis_in_tvalid),
        .peak       (peak_detected_i),
        .state      (state),
        .hit        (hit),
        .lost       (lost),
        .miss_count (miss_count_o)
    );
    assign state_debug_o = state;
    // symbol sequencer: peaks are taken at any cycle, sample counting only on valid
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = symbol_idx_o;
        locked_nx = locked_o;
        case (state)
            SEARCH: if (peak_detected_i) begin
                state_nx = ENTRY;
                cnt_nx   = '0;
                idx_nx   = SYM_PBCH1;
            end
            ALIGN: if (s_axis_in_tvalid) begin
                cnt_nx = cnt + 1'b1;
                if (cnt == WAIT_LAST) begin
                    state_nx = SYM;
                    cnt_nx   = '0;
                end
            end
            SYM: if (s_axis_in_tvalid) begin
                cnt_nx = cnt + 1'b1;
                if (cnt == SYM_LAST) begin
                    cnt_nx    = '0;
                    state_nx  = symbol_idx_o == SYM_PBCH2 ? TRACK : CP;
                    locked_nx = locked_o || symbol_idx_o == SYM_PBCH2;
                end
            end
            CP: if (s_axis_in_tvalid) begin
                cnt_nx = cnt + 1'b1;
                if (cnt == CP_LAST) begin
                    state_nx = SYM;
                    cnt_nx   = '0;
                    idx_nx   = symbol_idx_o + 2'd1;
                end
            end
            TRACK: if (hit) begin
                state_nx = ENTRY;
                cnt_nx   = '0;
                idx_nx   = SYM_PBCH1;
            end else if (lost) begin
                state_nx  = SEARCH;
                locked_nx = 1'b0;
            end
            default: state_nx = SEARCH;
        endcase
        sym_first = state_nx == SYM && cnt_nx == '0;
    end
    // start strobes stay up until the first valid sample of the window is consumed
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state          <= SEARCH;
            cnt            <= '0;
            symbol_idx_o   <= '0;
            locked_o       <= 1'b0;
            fft_enable_o   <= 1'b0;
            symbol_start_o <= 1'b0;
            PBCH_start_o   <= 1'b0;
            SSS_start_o    <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            symbol_idx_o   <= idx_nx;
            locked_o       <= locked_nx;
            fft_enable_o   <= state_nx == SYM;
            symbol_start_o <= sym_first;
            PBCH_start_o   <= sym_first && idx_nx[0];
            SSS_start_o    <= sym_first && idx_nx == SYM_SSS;
        end
    end
endmodule

// File: tb/tb_ssb_sync_ctrl.sv
// tb_ssb_sync_ctrl: directed checks of SSB windowing, period tracking, loss of lock and reset
module tb_ssb_sync_ctrl;
    logic       clk_i, reset_ni, s_axis_in_tvalid, peak_detected_i;
    logic       fft_enable_o, symbol_start_o, PBCH_start_o, SSS_start_o, locked_o;
    logic [1:0] symbol_idx_o, miss_count_o;
    logic [2:0] state_debug_o;
    int total, bad, pc, s, n1, n2, n3;

    ssb_sync_ctrl #(.SSB_PERIOD(1000)) dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .s_axis_in_tvalid (s_axis_in_tvalid),
        .peak_detected_i  (peak_detected_i),
        .fft_enable_o     (fft_enable_o),
        .symbol_start_o   (symbol_start_o),
        .symbol_idx_o     (symbol_idx_o),
        .PBCH_start_o     (PBCH_start_o),
        .SSS_start_o      (SSS_start_o),
        .locked_o         (locked_o),
        .miss_count_o     (miss_count_o),
        .state_debug_o    (state_debug_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pc = valid samples since the cycle after the last accepted peak (the DUT's period count)
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (s_axis_in_tvalid) pc++;
    endtask

    task automatic peak(input bit accepted);
        peak_detected_i = 1'b1;
        tick();
        peak_detected_i = 1'b0;
        if (accepted) pc = 0;
    endtask

    task automatic run_to(input int target);
        for (int g = 0; pc < target && g < 5000; g++) tick();
        check("run_to_bound", pc, target);
    endtask

    function automatic bit win(input int k);
        return (k >= 3 && k <= 258) || (k >= 277 && k <= 532) || (k >= 551 && k <= 806);
    endfunction

    initial begin
        total = 0; bad = 0; pc = 0;
        reset_ni = 1'b0; s_axis_in_tvalid = 1'b0; peak_detected_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_en", fft_enable_o, 0);
        check("rst_start", symbol_start_o, 0);
        check("rst_idx", symbol_idx_o, 0);
        check("rst_locked", locked_o, 0);
        check("rst_miss", miss_count_o, 0);
        check("rst_state", state_debug_o, 0);
        reset_ni = 1'b1;
        tick(); tick();
        check("idle_state", state_debug_o, 0);
        s_axis_in_tvalid = 1'b1;
        peak(1);
        for (int k = 0; k < 830; k++) begin
            check("b_en", fft_enable_o, win(k));
            check("b_start", symbol_start_o, k == 3 || k == 277 || k == 551);
            check("b_pbch", PBCH_start_o, k == 3 || k == 551);
            check("b_sss", SSS_start_o, k == 277);
            check("b_locked", locked_o, k >= 807);
            if (win(k)) check("b_idx", symbol_idx_o, k < 259 ? 1 : k < 533 ? 2 : 3);
            if (k == 0) check("b_align", state_debug_o, 1);
            if (k == 807) check("b_track", state_debug_o, 4);
            tick();
        end
        run_to(992);
        check("c_pre_state", state_debug_o, 4);
        peak(1);
        check("c_lo_state", state_debug_o, 1);
        check("c_lo_locked", locked_o, 1);
        check("c_lo_miss", miss_count_o, 0);
        run_to(3);
        check("c_lo_start", symbol_start_o, 1);
        check("c_lo_pbch", PBCH_start_o, 1);
        run_to(807);
        check("c_lo_track", state_debug_o, 4);
        run_to(1008);
        peak(1);
        check("c_hi_state", state_debug_o, 1);
        check("c_hi_locked", locked_o, 1);
        check("c_hi_miss", miss_count_o, 0);
        run_to(1008);
        check("c_close_pre", miss_count_o, 0);
        tick();
        pc = 8;
        check("c_close_miss", miss_count_o, 1);
        peak(0);
        check("c_late_state", state_debug_o, 4);
        check("c_late_miss", miss_count_o, 1);
        check("c_late_en", fft_enable_o, 0);
        run_to(1008);
        check("d_pre_miss", miss_count_o, 1);
        check("d_pre_en", fft_enable_o, 0);
        tick();
        pc = 8;
        check("d_miss2", miss_count_o, 2);
        check("d_miss2_state", state_debug_o, 4);
        check("d_miss2_locked", locked_o, 1);
        run_to(1008);
        tick();
        check("d_lost_state", state_debug_o, 0);
        check("d_lost_locked", locked_o, 0);
        check("d_lost_miss", miss_count_o, 0);
        peak(1);
        s = 0; n1 = 0; n2 = 0; n3 = 0;
        for (int c = 0; c < 4000 && s < 810; c++) begin
            s_axis_in_tvalid = c[0];
            if (s_axis_in_tvalid) begin
                check("e_en", fft_enable_o, win(s));
                check("e_start", symbol_start_o, s == 3 || s == 277 || s == 551);
                check("e_pbch", PBCH_start_o, s == 3 || s == 551);
                check("e_sss", SSS_start_o, s == 277);
                if (fft_enable_o) begin
                    if (symbol_idx_o == 2'd1) n1++;
                    if (symbol_idx_o == 2'd2) n2++;
                    if (symbol_idx_o == 2'd3) n3++;
                end
                if (s == 807) check("e_track", state_debug_o, 4);
                s++;
            end
            tick();
        end
        check("e_win1", n1, 256);
        check("e_win2", n2, 256);
        check("e_win3", n3, 256);
        check("e_locked", locked_o, 1);
        s_axis_in_tvalid = 1'b1;
        run_to(1000);
        peak(1);
        run_to(400);
        check("f_mid_state", state_debug_o, 2);
        peak(0);
        check("f_after_state", state_debug_o, 2);
        check("f_after_idx", symbol_idx_o, 2);
        run_to(532);
        check("f_last_en", fft_enable_o, 1);
        run_to(533);
        check("f_cp_en", fft_enable_o, 0);
        check("f_cp_state", state_debug_o, 3);
        run_to(551);
        check("f_s3_start", PBCH_start_o, 1);
        check("f_s3_sss", SSS_start_o, 0);
        check("f_s3_idx", symbol_idx_o, 3);
        run_to(807);
        check("f_track", state_debug_o, 4);
        run_to(1000);
        peak(1);
        run_to(265);
        check("g_cp_state", state_debug_o, 3);
        #2 reset_ni = 1'b0;
        #1;
        check("g_async_state", state_debug_o, 0);
        check("g_async_locked", locked_o, 0);
        check("g_async_idx", symbol_idx_o, 0);
        check("g_async_miss", miss_count_o, 0);
        @(posedge clk_i);
        #1 reset_ni = 1'b1;
        tick();
        check("g_rel_state", state_debug_o, 0);
        check("g_rel_en", fft_enable_o, 0);
        peak(1);
        run_to(3);
        check("g_restart_start", PBCH_start_o, 1);
        check("g_restart_idx", symbol_idx_o, 1);
        check("g_restart_en", fft_enable_o, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
